pan_lfo_scheduler: RTL and testbench
====================================

Name: pan_lfo_scheduler

Overview:
- Time-multiplexes one shared sine ROM (4096 x 16, registered read) across NUM_CH auto-pan LFO channels.
- On each sample tick, walks the channels in order. For each enabled channel it advances the phase accumulator, reads the ROM, and converts the sample to an unsigned pan value.
- Disabled channels pass their manual pan through.
- Sits between the voice/mixer pan inputs and the stereo panner. It replaces per-channel integrator+ROM pairs.

Parameters:
- NUM_CH, 4, number of LFO channels; legal range 1..8.
- PHASE_W, 24, phase accumulator width.
- ADDR_W, 12, ROM address width; address = phase[PHASE_W-1 -: ADDR_W].
- DATA_W, 16, ROM word / pan width.
- ROM_LAT, 1, ROM read latency in cycles; legal range 1..3.
- DEFAULT_INC, 24'h001B4F, reset value of every frequency increment.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SAMPLE_TICK  in  1  one-cycle strobe; starts one update sweep.
- PHASE_SYNC  in  1  level, sampled on the accepted tick; when 1, all phases load 0 before incrementing.
- FREQ_WE  in  1  write strobe for a frequency increment.
- FREQ_SEL  in  3  target channel for FREQ_WE; values >= NUM_CH are ignored.
- FREQ_IN  in  PHASE_W  increment value.
- EN  in  NUM_CH  per-channel auto-pan enable.
- MANUAL_PAN  in  NUM_CH*DATA_W  per-channel manual pan; channel i is bits [16i+15:16i].
- ROM_CS  out  1  ROM chip select.
- ROM_ADDR  out  ADDR_W  ROM address.
- ROM_DATA  in  DATA_W  ROM read data, signed two's complement.
- PAN_OUT  out  NUM_CH*DATA_W  registered per-channel pan, same packing as MANUAL_PAN.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  one-cycle pulse when a sweep completes.
- OVERRUN  out  1  one-cycle pulse when a tick arrives while BUSY.

Behaviour:
- Reset values:
  - all phases 0; all freq registers DEFAULT_INC;
  - every PAN_OUT lane 16'h4000; channel index 0;
  - ROM_CS, ROM_ADDR, BUSY, DONE and OVERRUN all 0; state IDLE.
- RESET mid-sweep aborts the sweep immediately; no partial update is kept beyond what was already captured.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, FINISH.
- IDLE:
  - On SAMPLE_TICK, go to ISSUE with ch=0 and BUSY=1.
  - Latch PHASE_SYNC.
- ISSUE for channel ch:
  - If EN[ch]=1:
    - phase[ch] <= (sync ? 0 : phase[ch]) + freq[ch], modulo 2^PHASE_W (wrap silent).
    - ROM_ADDR <= top ADDR_W bits of the new phase.
    - ROM_CS <= 1 for exactly one cycle.
    - Go to WAIT.
  - If EN[ch]=0:
    - Phase holds; the sync clear still applies.
    - PAN_OUT lane ch <= MANUAL_PAN lane ch.
    - No ROM access; advance ch, or go to FINISH after the last channel.
- WAIT: ROM_CS=0 and ROM_ADDR holds; stays ROM_LAT cycles, then goes to CAPTURE.
- CAPTURE:
  - PAN_OUT lane ch <= (ROM_DATA >>> 1) + 16'h4000, using signed arithmetic, truncated to DATA_W.
  - Result range is 0x0000..0x7FFF.
  - Advance ch, or go to FINISH after the last channel.
- FINISH: DONE=1 for one cycle, BUSY=0, return to IDLE.
- Sweep length: (2+ROM_LAT) cycles per enabled channel, 1 cycle per disabled channel, plus 1 cycle for FINISH.
- Tick handling:
  - SAMPLE_TICK while BUSY is dropped and OVERRUN pulses for 1 cycle.
  - SAMPLE_TICK in the FINISH cycle also counts as BUSY.
- Frequency writes:
  - FREQ_WE updates freq[FREQ_SEL] at the clock edge, in any state.
  - A write in the same cycle as that channel's ISSUE: ISSUE uses the old value, and the new value applies from the next sweep.
- EN changes mid-sweep take effect when that channel's ISSUE state is reached.
- PAN_OUT lanes not yet visited in a sweep keep their previous values.

Test Plan:
- Reset timing (NUM_CH=4, ROM_LAT=1, all EN=1):
  - Release RESET, pulse one tick.
  - Required: ROM_ADDR sequence 0x001, 0x001, 0x001, 0x001 (0x001B4F top 12 bits).
  - Required: ROM_CS pulses 3 cycles apart; DONE exactly 13 cycles after the tick; BUSY high for 12 cycles.
- Pan conversion with a ROM model:
  - ROM_DATA=0x8000 -> lane 0x0000.
  - ROM_DATA=0x7FFF -> lane 0x7FFF.
  - ROM_DATA=0x0000 -> lane 0x4000.
  - ROM_DATA=0xFFFF -> lane 0x3FFF.
- Mixed enables (EN=4'b0101, MANUAL_PAN lane1=0x1234, lane3=0x7000):
  - Lanes 1 and 3 load 0x1234 and 0x7000.
  - Only 2 ROM_CS pulses; DONE 9 cycles after the tick.
  - Phases 1 and 3 unchanged.
- Wrap-around and frequency write:
  - Write FREQ_IN=0xFFF000 to channel 0 and preload the phase via ticks.
  - Verify phase wraps modulo 2^24 (0xFFF000+0xFFF000 -> 0xFFE000, addr 0xFFE).
  - A FREQ_WE in channel 0's ISSUE cycle uses the old increment.
- Overrun: a second tick 4 cycles after the first -> OVERRUN pulses once; no second sweep; DONE count = 1.
- Sync and reset mid-sweep:
  - Tick with PHASE_SYNC=1 -> every ROM_ADDR equals freq[ch] top bits.
  - RESET asserted in WAIT -> next cycle all lanes read 0x4000, BUSY=0, ROM_CS=0.

Source files
------------

// File: rtl/pan_lfo_scheduler.sv
// Auto-pan LFO scheduler: one shared sine ROM serves NUM_CH phase accumulators,
// swept once per sample tick and converted into unsigned pan values.
module pan_lfo_scheduler #(
    parameter int                 NUM_CH      = 4,
    parameter int                 PHASE_W     = 24,
    parameter int                 ADDR_W      = 12,
    parameter int                 DATA_W      = 16,
    parameter int                 ROM_LAT     = 1,
    parameter logic [PHASE_W-1:0] DEFAULT_INC = 24'h001B4F
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       SAMPLE_TICK,
    input  logic                       PHASE_SYNC,
    input  logic                       FREQ_WE,
    input  logic [2:0]                 FREQ_SEL,
    input  logic [PHASE_W-1:0]         FREQ_IN,
    input  logic [NUM_CH-1:0]          EN,
    input  logic [NUM_CH*DATA_W-1:0]   MANUAL_PAN,
    output logic                       ROM_CS,
    output logic [ADDR_W-1:0]          ROM_ADDR,
    input  logic [DATA_W-1:0]          ROM_DATA,
    output logic [NUM_CH*DATA_W-1:0]   PAN_OUT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       OVERRUN
);

    localparam int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                WAIT_W    = 2;
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT - 1);
    localparam logic [DATA_W-1:0] PAN_MID   = {2'b01, {(DATA_W - 2){1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]          state_q,   state_d;
    logic [CH_W-1:0]     ch_q,      ch_d;
    logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                sync_q,    sync_d;
    logic                romCs_q,   romCs_d;
    logic [ADDR_W-1:0]   romAddr_q, romAddr_d;
    logic                overrun_q, overrun_d;

    logic [PHASE_W-1:0]  phase_q [NUM_CH];
    logic [PHASE_W-1:0]  phase_d [NUM_CH];
    logic [PHASE_W-1:0]  freq_q  [NUM_CH];
    logic [PHASE_W-1:0]  freq_d  [NUM_CH];
    logic [DATA_W-1:0]   pan_q   [NUM_CH];
    logic [DATA_W-1:0]   pan_d   [NUM_CH];

    logic [NUM_CH-1:0]   chHit;
    logic                enCur;
    logic [PHASE_W-1:0]  phaseCur;
    logic [PHASE_W-1:0]  freqCur;
    logic [DATA_W-1:0]   manualCur;
    logic [PHASE_W-1:0]  phaseNext;
    logic signed [DATA_W-1:0] romHalf;
    logic [DATA_W-1:0]   panConv;
    logic                advance;

    // Select the operands of the channel currently being visited.
    always_comb begin
        chHit     = '0;
        enCur     = 1'b0;
        phaseCur  = '0;
        freqCur   = '0;
        manualCur = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                chHit[i]  = 1'b1;
                enCur     = EN[i];
                phaseCur  = phase_q[i];
                freqCur   = freq_q[i];
                manualCur = MANUAL_PAN[i*DATA_W +: DATA_W];
            end
        end
    end

    assign phaseNext = (sync_q ? '0 : phaseCur) + freqCur;

    // Signed sample halved arithmetically, then biased to centre at PAN_MID.
    assign romHalf = $signed(ROM_DATA) >>> 1;
    assign panConv = $unsigned(romHalf) + PAN_MID;

    // Frequency writes land on the clock edge regardless of sweep state.
    always_comb begin
        freq_d = freq_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (FREQ_WE && (FREQ_SEL == 3'(i))) begin
                freq_d[i] = FREQ_IN;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        waitCnt_d = waitCnt_q;
        sync_d    = sync_q;
        romCs_d   = 1'b0;
        romAddr_d = romAddr_q;
        overrun_d = SAMPLE_TICK && (state_q != S_IDLE);
        phase_d   = phase_q;
        pan_d     = pan_q;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (SAMPLE_TICK) begin
                    state_d = S_ISSUE;
                    ch_d    = '0;
                    sync_d  = PHASE_SYNC;
                end
            end
            S_ISSUE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (chHit[i]) begin
                        if (enCur) begin
                            phase_d[i] = phaseNext;
                        end else begin
                            if (sync_q) begin
                                phase_d[i] = '0;
                            end
                            pan_d[i] = manualCur;
                        end
                    end
                end
                if (enCur) begin
                    romCs_d   = 1'b1;
                    romAddr_d = phaseNext[PHASE_W-1 -: ADDR_W];
                    waitCnt_d = '0;
                    state_d   = S_WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (chHit[i]) begin
                        pan_d[i] = panConv;
                    end
                end
                advance = 1'b1;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (ch_q == LAST_CH) begin
                state_d = S_FINISH;
            end else begin
                ch_d    = ch_q + CH_W'(1);
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            waitCnt_q <= '0;
            sync_q    <= 1'b0;
            romCs_q   <= 1'b0;
            romAddr_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= '0;
                freq_q[i]  <= DEFAULT_INC;
                pan_q[i]   <= PAN_MID;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            waitCnt_q <= waitCnt_d;
            sync_q    <= sync_d;
            romCs_q   <= romCs_d;
            romAddr_q <= romAddr_d;
            overrun_q <= overrun_d;
            phase_q   <= phase_d;
            freq_q    <= freq_d;
            pan_q     <= pan_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pan
        assign PAN_OUT[g*DATA_W +: DATA_W] = pan_q[g];
    end

    assign ROM_CS   = romCs_q;
    assign ROM_ADDR = romAddr_q;
    assign OVERRUN  = overrun_q;
    assign BUSY     = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
    assign DONE     = (state_q == S_FINISH);

endmodule

// File: tb/tb_pan_lfo_scheduler.sv
// Self-checking bench for pan_lfo_scheduler: registered ROM model plus a
// phase/pan reference model feeding address and lane scoreboards.
`timescale 1ns/1ps
module tb_pan_lfo_scheduler;

    localparam logic [23:0] DEF_INC = 24'h001B4F;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        SAMPLE_TICK = 1'b0;
    logic        PHASE_SYNC = 1'b0;
    logic        FREQ_WE = 1'b0;
    logic [2:0]  FREQ_SEL = 3'd0;
    logic [23:0] FREQ_IN = 24'h0;
    logic [3:0]  EN = 4'h0;
    logic [63:0] MANUAL_PAN = 64'h0;
    logic        ROM_CS;
    logic [11:0] ROM_ADDR;
    logic [15:0] ROM_DATA = 16'h0;
    logic [63:0] PAN_OUT;
    logic        BUSY;
    logic        DONE;
    logic        OVERRUN;

    always #10 CLOCK_50 = ~CLOCK_50;

    pan_lfo_scheduler #(
        .NUM_CH(4), .PHASE_W(24), .ADDR_W(12), .DATA_W(16), .ROM_LAT(1), .DEFAULT_INC(DEF_INC)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK), .PHASE_SYNC(PHASE_SYNC),
        .FREQ_WE(FREQ_WE), .FREQ_SEL(FREQ_SEL), .FREQ_IN(FREQ_IN), .EN(EN),
        .MANUAL_PAN(MANUAL_PAN), .ROM_CS(ROM_CS), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
        .PAN_OUT(PAN_OUT), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
    );

    // Sine ROM stand-in: registered read, one cycle latency, gated by chip select.
    logic [15:0] romMem [4096];
    always @(posedge CLOCK_50) begin
        if (ROM_CS) ROM_DATA <= romMem[ROM_ADDR];
    end

    int testsRun = 0;
    int testsFailed = 0;

    logic [23:0] mPhase [4];
    logic [23:0] mFreq  [4];
    logic [15:0] mPan   [4];
    int          mDoneOff;
    logic [11:0] expAddrQ [$];
    logic [11:0] obsAddrQ [$];
    int          csOffQ [$];
    int          doneOff, doneCnt, busyCnt, overrunCnt, overrunOff;

    function automatic logic [15:0] conv(input logic [15:0] d);
        int s;
        s = int'($signed(d));
        s = (s >>> 1) + 16384;
        return s[15:0];
    endfunction

    task automatic resetModel();
        for (int c = 0; c < 4; c++) begin
            mPhase[c] = 24'h0;
            mFreq[c]  = DEF_INC;
            mPan[c]   = 16'h4000;
        end
    endtask

    // Reference model for one sweep: pushes expected ROM addresses, updates lanes.
    task automatic predictSweep(input logic [3:0] en, input bit sync);
        logic [11:0] a;
        mDoneOff = 1;
        for (int c = 0; c < 4; c++) begin
            if (sync) mPhase[c] = 24'h0;
            if (en[c]) begin
                mPhase[c] = mPhase[c] + mFreq[c];
                a = mPhase[c][23:12];
                expAddrQ.push_back(a);
                mPan[c] = conv(romMem[a]);
                mDoneOff += 3;
            end else begin
                mPan[c] = MANUAL_PAN[c*16 +: 16];
                mDoneOff += 1;
            end
        end
    endtask

    // Issues one tick (called at a negedge) and records DUT activity for budget cycles.
    task automatic runSweep(input bit sync, input int secondTickAt, input int freqWriteAt, input int budget);
        obsAddrQ.delete();
        csOffQ.delete();
        doneOff = -1; doneCnt = 0; busyCnt = 0; overrunCnt = 0; overrunOff = -1;
        PHASE_SYNC  = sync;
        SAMPLE_TICK = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLOCK_50);
            SAMPLE_TICK = (k == secondTickAt);
            FREQ_WE     = (k == freqWriteAt);
            PHASE_SYNC  = 1'b0;
            if (ROM_CS === 1'b1) begin
                obsAddrQ.push_back(ROM_ADDR);
                csOffQ.push_back(k);
            end
            if (BUSY === 1'b1) busyCnt++;
            if (DONE === 1'b1) begin
                doneCnt++;
                if (doneOff < 0) doneOff = k;
            end
            if (OVERRUN === 1'b1) begin
                overrunCnt++;
                if (overrunOff < 0) overrunOff = k;
            end
        end
        SAMPLE_TICK = 1'b0;
        FREQ_WE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (PAN_OUT[c*16 +: 16] !== 16'h4000) begin
                testsFailed++;
                $display("[TB] FAIL reset_lane%0d: got %h expected 4000", c, PAN_OUT[c*16 +: 16]);
            end
        end
        testsRun++;
        if ({ROM_CS, BUSY, DONE, OVERRUN} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got cs/busy/done/ovr=%b expected 0000", {ROM_CS, BUSY, DONE, OVERRUN});
        end
        testsRun++;
        if (ROM_ADDR !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_addr: got %h expected 000", ROM_ADDR);
        end
        RESET = 1'b0;
        @(negedge CLOCK_50);
        resetModel();
    endtask

    task automatic test_reset_timing();
        logic [11:0] expA, obsA;
        EN = 4'hF;
        predictSweep(4'hF, 1'b0);
        runSweep(1'b0, 0, 0, 20);
        testsRun++;
        if (obsAddrQ.size() != 4) begin
            testsFailed++;
            $display("[TB] FAIL timing_cs_count: got %0d expected 4", obsAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            expA = expAddrQ.pop_front();
            obsA = obsAddrQ.pop_front();
            testsRun++;
            if (obsA !== expA || obsA !== 12'h001) begin
                testsFailed++;
                $display("[TB] FAIL timing_addr: got %h expected %h", obsA, expA);
            end
        end
        for (int i = 0; i < csOffQ.size() && i < 4; i++) begin
            testsRun++;
            if (csOffQ[i] != 2 + 3 * i) begin
                testsFailed++;
                $display("[TB] FAIL timing_cs_cycle%0d: got %0d expected %0d", i, csOffQ[i], 2 + 3 * i);
            end
        end
        testsRun++;
        if (doneOff != 13 || doneCnt != 1) begin
            testsFailed++;
            $display("[TB] FAIL timing_done: got offset %0d count %0d expected 13 and 1", doneOff, doneCnt);
        end
        testsRun++;
        if (busyCnt != 12) begin
            testsFailed++;
            $display("[TB] FAIL timing_busy: got %0d cycles expected 12", busyCnt);
        end
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (PAN_OUT[c*16 +: 16] !== mPan[c]) begin
                testsFailed++;
                $display("[TB] FAIL timing_lane%0d: got %h expected %h", c, PAN_OUT[c*16 +: 16], mPan[c]);
            end
        end
        expAddrQ.delete();
    endtask

    task automatic test_pan_conversion();
        logic [15:0] romVals [4];
        logic [15:0] panVals [4];
        logic [11:0] a, expA, obsA;
        romVals = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
        panVals = '{16'h0000, 16'h7FFF, 16'h4000, 16'h3FFF};
        EN = 4'hF;
        for (int v = 0; v < 4; v++) begin
            a = 12'((mPhase[0] + mFreq[0]) >> 12);
            romMem[a] = romVals[v];
            predictSweep(4'hF, 1'b0);
            runSweep(1'b0, 0, 0, 16);
            testsRun++;
            if (obsAddrQ.size() != expAddrQ.size()) begin
                testsFailed++;
                $display("[TB] FAIL conv_cs_count: got %0d expected %0d", obsAddrQ.size(), expAddrQ.size());
            end
            while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
                expA = expAddrQ.pop_front();
                obsA = obsAddrQ.pop_front();
                testsRun++;
                if (obsA !== expA) begin
                    testsFailed++;
                    $display("[TB] FAIL conv_addr: got %h expected %h", obsA, expA);
                end
            end
            expAddrQ.delete();
            for (int c = 0; c < 4; c++) begin
                testsRun++;
                if (PAN_OUT[c*16 +: 16] !== panVals[v]) begin
                    testsFailed++;
                    $display("[TB] FAIL conv_%h_lane%0d: got %h expected %h", romVals[v], c, PAN_OUT[c*16 +: 16], panVals[v]);
                end
            end
        end
    endtask

    task automatic test_mixed_enables();
        logic [11:0] expA, obsA;
        EN = 4'b0101;
        MANUAL_PAN = {16'h7000, 16'hAAAA, 16'h1234, 16'h5555};
        for (int pass = 0; pass < 2; pass++) begin
            predictSweep(EN, 1'b0);
            runSweep(1'b0, 0, 0, 16);
            testsRun++;
            if (obsAddrQ.size() != expAddrQ.size()) begin
                testsFailed++;
                $display("[TB] FAIL mixed%0d_cs_count: got %0d expected %0d", pass, obsAddrQ.size(), expAddrQ.size());
            end
            while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
                expA = expAddrQ.pop_front();
                obsA = obsAddrQ.pop_front();
                testsRun++;
                if (obsA !== expA) begin
                    testsFailed++;
                    $display("[TB] FAIL mixed%0d_addr: got %h expected %h", pass, obsA, expA);
                end
            end
            expAddrQ.delete();
            testsRun++;
            if (doneOff != mDoneOff) begin
                testsFailed++;
                $display("[TB] FAIL mixed%0d_done: got offset %0d expected %0d", pass, doneOff, mDoneOff);
            end
            for (int c = 0; c < 4; c++) begin
                testsRun++;
                if (PAN_OUT[c*16 +: 16] !== mPan[c]) begin
                    testsFailed++;
                    $display("[TB] FAIL mixed%0d_lane%0d: got %h expected %h", pass, c, PAN_OUT[c*16 +: 16], mPan[c]);
                end
            end
            if (pass == 0) begin
                testsRun++;
                if (PAN_OUT[16 +: 16] !== 16'h1234 || PAN_OUT[48 +: 16] !== 16'h7000 || doneOff != 9) begin
                    testsFailed++;
                    $display("[TB] FAIL mixed_manual: got lane1 %h lane3 %h done %0d expected 1234 7000 9",
                             PAN_OUT[16 +: 16], PAN_OUT[48 +: 16], doneOff);
                end
                EN = 4'hF;
            end
        end
    endtask

    task automatic test_wrap_freq_write();
        logic [11:0] expA, obsA;
        FREQ_SEL = 3'd0;
        FREQ_IN  = 24'hFFF000;
        FREQ_WE  = 1'b1;
        @(negedge CLOCK_50);
        FREQ_WE = 1'b0;
        mFreq[0] = 24'hFFF000;
        EN = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            predictSweep(EN, s == 0);
            if (s == 2) FREQ_IN = 24'h010000;
            runSweep(s == 0, 0, (s == 2) ? 1 : 0, 12);
            if (s == 2) mFreq[0] = 24'h010000;
            testsRun++;
            if (obsAddrQ.size() != 1) begin
                testsFailed++;
                $display("[TB] FAIL wrap%0d_cs_count: got %0d expected 1", s, obsAddrQ.size());
            end
            while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
                expA = expAddrQ.pop_front();
                obsA = obsAddrQ.pop_front();
                testsRun++;
                if (obsA !== expA) begin
                    testsFailed++;
                    $display("[TB] FAIL wrap%0d_addr: got %h expected %h", s, obsA, expA);
                end
            end
            expAddrQ.delete();
            testsRun++;
            if (doneOff != 7) begin
                testsFailed++;
                $display("[TB] FAIL wrap%0d_done: got offset %0d expected 7", s, doneOff);
            end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] expA, obsA;
        EN = 4'hF;
        predictSweep(EN, 1'b0);
        runSweep(1'b0, 4, 0, 30);
        testsRun++;
        if (overrunCnt != 1 || overrunOff != 5) begin
            testsFailed++;
            $display("[TB] FAIL overrun_pulse: got count %0d at %0d expected 1 at 5", overrunCnt, overrunOff);
        end
        testsRun++;
        if (doneCnt != 1 || obsAddrQ.size() != 4) begin
            testsFailed++;
            $display("[TB] FAIL overrun_single_sweep: got done %0d cs %0d expected 1 and 4", doneCnt, obsAddrQ.size());
        end
        while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
            expA = expAddrQ.pop_front();
            obsA = obsAddrQ.pop_front();
            testsRun++;
            if (obsA !== expA) begin
                testsFailed++;
                $display("[TB] FAIL overrun_addr: got %h expected %h", obsA, expA);
            end
        end
        expAddrQ.delete();
    endtask

    task automatic test_back_to_back();
        logic [11:0] expA, obsA;
        EN = 4'hF;
        for (int s = 0; s < 2; s++) begin
            predictSweep(EN, 1'b0);
            if (s == 1) predictSweep(EN, 1'b0);
            runSweep(1'b0, 13 + s, 0, 30);
            testsRun++;
            if (overrunCnt != 1 - s || doneCnt != 1 + s) begin
                testsFailed++;
                $display("[TB] FAIL b2b_tick%0d: got overrun %0d done %0d expected %0d and %0d",
                         13 + s, overrunCnt, doneCnt, 1 - s, 1 + s);
            end
            testsRun++;
            if (obsAddrQ.size() != expAddrQ.size()) begin
                testsFailed++;
                $display("[TB] FAIL b2b_cs_count: got %0d expected %0d", obsAddrQ.size(), expAddrQ.size());
            end
            while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
                expA = expAddrQ.pop_front();
                obsA = obsAddrQ.pop_front();
                testsRun++;
                if (obsA !== expA) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_addr: got %h expected %h", obsA, expA);
                end
            end
            expAddrQ.delete();
        end
    endtask

    task automatic test_sync_reset();
        logic [11:0] expA, obsA;
        EN = 4'hF;
        for (int s = 0; s < 2; s++) begin
            predictSweep(EN, s == 0);
            runSweep(s == 0, 0, 0, 16);
            testsRun++;
            if (obsAddrQ.size() != 4) begin
                testsFailed++;
                $display("[TB] FAIL sync%0d_cs_count: got %0d expected 4", s, obsAddrQ.size());
            end
            while (expAddrQ.size() > 0 && obsAddrQ.size() > 0) begin
                expA = expAddrQ.pop_front();
                obsA = obsAddrQ.pop_front();
                testsRun++;
                if (obsA !== expA) begin
                    testsFailed++;
                    $display("[TB] FAIL sync%0d_addr: got %h expected %h", s, obsA, expA);
                end
            end
            expAddrQ.delete();
            if (s == 0) begin
                // Mid-sweep reset: tick, reach ch0's WAIT cycle, then assert RESET.
                SAMPLE_TICK = 1'b1;
                @(negedge CLOCK_50);
                SAMPLE_TICK = 1'b0;
                @(negedge CLOCK_50);
                testsRun++;
                if (ROM_CS !== 1'b1 || BUSY !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_in_wait: got cs %b busy %b expected 1 1", ROM_CS, BUSY);
                end
                RESET = 1'b1;
                @(negedge CLOCK_50);
                for (int c = 0; c < 4; c++) begin
                    testsRun++;
                    if (PAN_OUT[c*16 +: 16] !== 16'h4000) begin
                        testsFailed++;
                        $display("[TB] FAIL midreset_lane%0d: got %h expected 4000", c, PAN_OUT[c*16 +: 16]);
                    end
                end
                testsRun++;
                if (BUSY !== 1'b0 || ROM_CS !== 1'b0 || DONE !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL midreset_flags: got busy %b cs %b done %b expected 0 0 0", BUSY, ROM_CS, DONE);
                end
                RESET = 1'b0;
                @(negedge CLOCK_50);
                resetModel();
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            romMem[a] = 16'(a * 16'h0123 + 16'h2468);
        end
        resetModel();
        test_reset();
        test_reset_timing();
        test_pan_conversion();
        test_mixed_enables();
        test_wrap_freq_write();
        test_overrun();
        test_back_to_back();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
